// File: rtl/ysyx_axi_rd_arbiter_if.sv
// AXI4 read-address / read-data channel bundle shared by the arbiter (master) and the memory side (slave).
interface ysyx_axi_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [3:0]        arid;
  logic [2:0]        arsize;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic [3:0]        rid;
  logic              rlast;

  modport master (
    output araddr, arvalid, arid, arsize, arlen, arburst, rready,
    input  arready, rvalid, rdata, rresp, rid, rlast
  );

  modport slave (
    input  araddr, arvalid, arid, arsize, arlen, arburst, rready,
    output arready, rvalid, rdata, rresp, rid, rlast
  );
endinterface

// File: rtl/ysyx_axi_rd_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 read channel between IFU and LSU,
// with one transaction outstanding and an R-phase watchdog.
module ysyx_axi_rd_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [3:0]  ID_IFU    = 4'd0,
  parameter logic [3:0]  ID_LSU    = 4'd1,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic [31:0]           ifu_rdata_o,
  output logic                  ifu_rvalid_o,
  output logic [1:0]            ifu_rresp_o,
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  input  logic [7:0]            lsu_rstrb,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  output logic [1:0]            lsu_rresp_o,
  ysyx_axi_rd_arbiter_if.master io_master,
  output logic                  busy_o
);

  localparam int unsigned      CNT_W    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TO_CYCLES > 0) ? CNT_W'(TO_CYCLES - 1) : '0;
  localparam logic [1:0]       SLVERR   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_e;

  function automatic logic [2:0] lsu_size(input logic [7:0] strb);
    case (strb)
      8'h01:   return 3'd0;
      8'h03:   return 3'd1;
      8'h0F:   return 3'd2;
      8'hFF:   return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [31:0] ifu_lane(input logic [63:0] d, input logic hi);
    return hi ? d[63:32] : d[31:0];
  endfunction

  // Right-align the addressed bytes, then keep only the lanes the load asked for.
  function automatic logic [31:0] lsu_lane(input logic [63:0] d, input logic [2:0] off,
                                           input logic [7:0] strb);
    logic [63:0] sh;
    logic [31:0] m;
    sh = d >> {off, 3'b000};
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return sh[31:0] & m;
  endfunction

  state_e            state_q, state_d;
  logic              last_g_q, last_g_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rstrb_q, rstrb_d;
  logic [3:0]        id_q, id_d;
  logic [2:0]        size_q, size_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ifu_data_q, ifu_data_d, lsu_data_q, lsu_data_d;
  logic [1:0]        ifu_resp_q, ifu_resp_d, lsu_resp_q, lsu_resp_d;

  logic       gnt;
  logic       wd_expired;
  logic [1:0] beat_resp;

  assign gnt        = (ifu_arvalid && lsu_arvalid) ? ~last_g_q : lsu_arvalid;
  assign wd_expired = (TO_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign beat_resp  = (io_master.rid != id_q) ? SLVERR : io_master.rresp;

  always_comb begin
    state_d    = state_q;
    last_g_d   = last_g_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    rstrb_d    = rstrb_q;
    id_d       = id_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    ifu_data_d = ifu_data_q;
    ifu_resp_d = ifu_resp_q;
    lsu_data_d = lsu_data_q;
    lsu_resp_d = lsu_resp_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          grant_d = gnt;
          addr_d  = gnt ? lsu_araddr : ifu_araddr;
          rstrb_d = lsu_rstrb;
          id_d    = gnt ? ID_LSU : ID_IFU;
          size_d  = gnt ? lsu_size(lsu_rstrb) : 3'b010;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (io_master.arready) begin
          cnt_d   = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        // A real last beat wins over a watchdog expiry landing in the same cycle.
        if (io_master.rvalid && io_master.rlast) begin
          if (grant_q) begin
            lsu_data_d = lsu_lane(io_master.rdata, addr_q[2:0], rstrb_q);
            lsu_resp_d = beat_resp;
          end else begin
            ifu_data_d = ifu_lane(io_master.rdata, addr_q[2]);
            ifu_resp_d = beat_resp;
          end
          state_d = S_RESP;
        end else if (wd_expired) begin
          if (grant_q) begin
            lsu_data_d = '0;
            lsu_resp_d = SLVERR;
          end else begin
            ifu_data_d = '0;
            ifu_resp_d = SLVERR;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        last_g_d = grant_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_g_q   <= 1'b0;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      rstrb_q    <= '0;
      id_q       <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      ifu_data_q <= '0;
      ifu_resp_q <= '0;
      lsu_data_q <= '0;
      lsu_resp_q <= '0;
    end else begin
      state_q    <= state_d;
      last_g_q   <= last_g_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      rstrb_q    <= rstrb_d;
      id_q       <= id_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      ifu_data_q <= ifu_data_d;
      ifu_resp_q <= ifu_resp_d;
      lsu_data_q <= lsu_data_d;
      lsu_resp_q <= lsu_resp_d;
    end
  end

  assign io_master.araddr  = addr_q;
  assign io_master.arvalid = (state_q == S_AR);
  assign io_master.arid    = id_q;
  assign io_master.arsize  = size_q;
  assign io_master.arlen   = 8'd0;
  assign io_master.arburst = 2'b01;
  assign io_master.rready  = (state_q == S_R);

  assign busy_o       = (state_q != S_IDLE);
  assign ifu_rvalid_o = (state_q == S_RESP) && !grant_q;
  assign lsu_rvalid_o = (state_q == S_RESP) && grant_q;
  assign ifu_rdata_o  = ifu_data_q;
  assign ifu_rresp_o  = ifu_resp_q;
  assign lsu_rdata_o  = lsu_data_q;
  assign lsu_rresp_o  = lsu_resp_q;

endmodule
